// File: rtl/des_pkg.sv
// des_pkg: shared DES tables, constants, state enum and permutation helpers for the encrypt/decrypt cores
package des_pkg;
  localparam int NUM_ROUNDS = 16;
  localparam int ROUND_KEY_W = 48;
  localparam int BLOCK_W = 64;
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
  localparam int IP_T [1:64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                 57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int IPI_T [1:64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                  38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                  36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                  34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int E_T [1:48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                                16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [1:32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                                2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam logic [3:0] SBOX [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};
  function automatic logic [1:64] ip_permutation(input logic [1:64] x);
    logic [1:64] y;
    for (int i = 1; i <= 64; i++) y[i] = x[IP_T[i]];
    return y;
  endfunction
  function automatic logic [1:64] ip_inverse_permutation(input logic [1:64] x);
    logic [1:64] y;
    for (int i = 1; i <= 64; i++) y[i] = x[IPI_T[i]];
    return y;
  endfunction
  function automatic logic [1:48] e_expand(input logic [1:32] x);
    logic [1:48] y;
    for (int i = 1; i <= 48; i++) y[i] = x[E_T[i]];
    return y;
  endfunction
  function automatic logic [1:32] p_permute(input logic [1:32] x);
    logic [1:32] y;
    for (int i = 1; i <= 32; i++) y[i] = x[P_T[i]];
    return y;
  endfunction
  function automatic logic [1:32] s_layer(input logic [1:48] x);
    logic [1:32] y;
    logic [1:6] b;
    for (int i = 0; i < 8; i++) begin
      b = x[6*i+1 +: 6];
      y[4*i+1 +: 4] = SBOX[i][{b[1], b[6], b[2:5]}];
    end
    return y;
  endfunction
  function automatic logic [1:NUM_ROUNDS*ROUND_KEY_W] key_reverse(input logic [1:NUM_ROUNDS*ROUND_KEY_W] k);
    logic [1:NUM_ROUNDS*ROUND_KEY_W] y;
    for (int i = 0; i < NUM_ROUNDS; i++) y[ROUND_KEY_W*i+1 +: ROUND_KEY_W] = k[ROUND_KEY_W*(NUM_ROUNDS-1-i)+1 +: ROUND_KEY_W];
    return y;
  endfunction
endpackage

// File: rtl/des_feistel_f.sv
// des_feistel_f: combinational DES round function f = P(S(E(r) ^ k)); ports r[1:32], k[1:48] -> f[1:32]
module des_feistel_f
  import des_pkg::*;
(
  input  logic [1:32] r,
  input  logic [1:48] k,
  output logic [1:32] f
);
  assign f = p_permute(s_layer(e_expand(r) ^ k));
endmodule

// File: rtl/des_decryption_unroll2.sv
// des_decryption_unroll2: 2-rounds/clk DES decrypt (clk, rst, start, ciphertext, round_keys -> busy, done, result); DES_DEC_KEY_LATCH_EN latches keys at start
module des_decryption_unroll2
  import des_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [1:BLOCK_W]                  ciphertext,
  input  logic [1:NUM_ROUNDS*ROUND_KEY_W]   round_keys,
  output logic                              busy,
  output logic                              done,
  output logic [1:BLOCK_W]                  result
);
  if (ROUNDS_PER_CYCLE != 2) begin : g_bad_rpc
    $error("ROUNDS_PER_CYCLE must be 2");
  end
  state_t state, state_n;
  logic [2:0] cnt;
  logic [1:32] l, r, r1, r2, fa, fb;
  logic [1:ROUND_KEY_W] k_a, k_b;
  logic [1:NUM_ROUNDS*ROUND_KEY_W] keys_rev;
  assign keys_rev = key_reverse(round_keys);
`ifdef DES_DEC_KEY_LATCH_EN
  logic [1:NUM_ROUNDS*ROUND_KEY_W] key_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) key_q <= '0;
    else if (state == IDLE && start) key_q <= keys_rev;
    else if (state == ROUND) key_q <= key_q << (2 * ROUND_KEY_W);
  end
  assign {k_a, k_b} = key_q[1:2*ROUND_KEY_W];
`else
  logic [1:2*ROUND_KEY_W] pair [8];
  always_comb for (int i = 0; i < 8; i++) pair[i] = keys_rev[2*ROUND_KEY_W*i+1 +: 2*ROUND_KEY_W];
  assign {k_a, k_b} = pair[cnt];
`endif
  des_feistel_f u_f0 (.r(r),  .k(k_a), .f(fa));
  des_feistel_f u_f1 (.r(r1), .k(k_b), .f(fb));
  assign r1 = l ^ fa;
  assign r2 = r ^ fb;
  always_comb state_n = (state == IDLE) ? (start ? ROUND : IDLE) : (state == ROUND) ? (cnt == 3'd7 ? DONE : ROUND) : IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      l      <= '0;
      r      <= '0;
      result <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        {l, r} <= ip_permutation(ciphertext);
        cnt    <= '0;
      end else if (state == ROUND) begin
        l   <= r1;
        r   <= r2;
        cnt <= cnt + 3'd1;
        if (cnt == 3'd7) result <= ip_inverse_permutation({r2, r1});
      end
    end
  end
  assign busy = (state != IDLE);
  assign done = (state == DONE);
endmodule

// File: tb/tb_des_decryption_unroll2.sv
// tb_des_decryption_unroll2: directed + random round-trip bench with a standalone DES encryption/key-schedule model
module tb_des_decryption_unroll2;
  import des_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [1:64] ciphertext = '0;
  logic [1:768] round_keys = '0;
  logic busy, done;
  logic [1:64] result;
  int errors = 0;
  int checks = 0;
  localparam int PC1 [1:56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2 [1:48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int SH [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  des_decryption_unroll2 dut (.clk(clk), .rst(rst), .start(start), .ciphertext(ciphertext),
                              .round_keys(round_keys), .busy(busy), .done(done), .result(result));
  always #5 clk = ~clk;
  function automatic logic [1:768] ksched(input logic [1:64] key);
    logic [1:28] c, d;
    logic [1:56] cd;
    logic [1:768] ks;
    for (int i = 1; i <= 56; i++) cd[i] = key[PC1[i]];
    c = cd[1:28];
    d = cd[29:56];
    for (int n = 0; n < 16; n++) begin
      for (int s = 0; s < SH[n]; s++) begin
        c = {c[2:28], c[1]};
        d = {d[2:28], d[1]};
      end
      cd = {c, d};
      for (int j = 1; j <= 48; j++) ks[48*n+j] = cd[PC2[j]];
    end
    return ks;
  endfunction
  function automatic logic [1:32] mf(input logic [1:32] r, input logic [1:48] k);
    logic [1:48] x;
    logic [1:32] s, y;
    int row, col;
    for (int i = 1; i <= 48; i++) x[i] = r[E_T[i]] ^ k[i];
    for (int b = 0; b < 8; b++) begin
      row = 2 * int'(x[6*b+1]) + int'(x[6*b+6]);
      col = 8 * int'(x[6*b+2]) + 4 * int'(x[6*b+3]) + 2 * int'(x[6*b+4]) + int'(x[6*b+5]);
      s[4*b+1 +: 4] = SBOX[b][16*row+col];
    end
    for (int i = 1; i <= 32; i++) y[i] = s[P_T[i]];
    return y;
  endfunction
  function automatic logic [1:64] enc(input logic [1:64] pt, input logic [1:768] ks);
    logic [1:64] x, y;
    logic [1:32] l, r, t;
    for (int i = 1; i <= 64; i++) x[i] = pt[IP_T[i]];
    l = x[1:32];
    r = x[33:64];
    for (int n = 0; n < 16; n++) begin
      t = r;
      r = l ^ mf(r, ks[48*n+1 +: 48]);
      l = t;
    end
    x = {r, l};
    for (int i = 1; i <= 64; i++) y[i] = x[IPI_T[i]];
    return y;
  endfunction
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic run(input logic [1:64] ct, input logic [1:768] ks, input logic [1:64] exp, input bit rep, input string tag);
    int n;
    @(negedge clk);
    ciphertext = ct;
    round_keys = ks;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
`ifdef DES_DEC_KEY_LATCH_EN
    round_keys = {24{$urandom()}};
`endif
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
      start = rep && !done && (n == 2 || n == 5);
      if (start) ciphertext = ~ct;
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(n), 64'd8);
    check({tag, "_result"}, result, exp);
  endtask
  initial begin
    logic [1:64] key, pt, ct;
    logic [1:768] ks;
    int nd;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_result", result, 64'd0);
    rst = 1'b0;
    run(64'h85E813540F0AB405, ksched(64'h133457799BBCDFF1), 64'h0123456789ABCDEF, 1'b0, "kat1");
    run(64'h8CA64DE9C1B123A7, ksched(64'h0000000000000000), 64'h0000000000000000, 1'b0, "kat0");
    key = {$urandom(), $urandom()};
    pt = {$urandom(), $urandom()};
    ks = ksched(key);
    run(enc(pt, ks), ks, pt, 1'b1, "repulse");
    key = {$urandom(), $urandom()};
    pt = {$urandom(), $urandom()};
    ks = ksched(key);
    ct = enc(pt, ks);
    @(negedge clk);
    ciphertext = ct;
    round_keys = ks;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("midop_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", result, 64'd0);
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("rst_no_done", 64'(nd), 64'd0);
    rst = 1'b0;
    run(ct, ks, pt, 1'b0, "after_rst");
    for (int i = 0; i < 1000; i++) begin
      key = {$urandom(), $urandom()};
      pt = {$urandom(), $urandom()};
      ks = ksched(key);
      run(enc(pt, ks), ks, pt, 1'b0, "roundtrip");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
